// File: rtl/gray_to_distance.sv
// Gray zone receiver: stability filter, single-step check, and
// zone/distance reconstruction with lock timeout and fault latch.
module gray_to_distance #(
  parameter int STABLE_CYCLES = 3,
  parameter int TIMEOUT       = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] gray_in,
  input  logic       gray_valid,
  input  logic       err_clr,
  output logic [2:0] zone,
  output logic [4:0] distance,
  output logic       dist_valid,
  output logic [1:0] direction,
  output logic       update,
  output logic       step_error
);

  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [3:0] STAB = 4'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    ACQ  = 2'd0,
    LOCK = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t      r_state, w_state_n;
  logic [2:0]  r_cand, w_cand_n;
  logic [3:0]  r_cnt, w_cnt_n;
  logic [IW-1:0] r_idle, w_idle_n;
  logic [2:0]  r_zone, w_zone_n;
  logic [4:0]  r_dist, w_dist_n;
  logic        r_dv, w_dv_n;
  logic [1:0]  r_dir, w_dir_n;
  logic        r_upd, w_upd_n;
  logic        r_serr, w_serr_n;

  logic [2:0]  w_bin;
  logic [2:0]  w_code;
  logic [2:0]  w_diff;
  logic        w_one;
  logic        w_filt;
  logic [3:0]  w_cnt_f;
  logic        w_commit;
  logic        w_tout;

  assign w_bin[2] = gray_in[2];
  assign w_bin[1] = gray_in[2] ^ gray_in[1];
  assign w_bin[0] = gray_in[2] ^ gray_in[1] ^ gray_in[0];

  assign w_code = r_zone ^ {1'b0, r_zone[2:1]};
  assign w_diff = gray_in ^ w_code;
  assign w_one  = (w_diff != 3'd0) &&
                  ((w_diff & (w_diff - 3'd1)) == 3'd0);

  assign w_filt  = gray_valid && (r_state != ERR);
  assign w_cnt_f = (gray_in != r_cand) ? 4'd1 :
                   (r_cnt >= STAB) ? STAB : r_cnt + 4'd1;
  assign w_commit = w_filt && (w_cnt_f == STAB);

  // Idle count reaches TIMEOUT on this edge
  assign w_tout = (TIMEOUT != 0) && !gray_valid &&
                  (r_idle == IW'(TIMEOUT - 1));

  always_comb begin
    w_state_n = r_state;
    w_cand_n  = r_cand;
    w_cnt_n   = r_cnt;
    w_idle_n  = r_idle;
    w_zone_n  = r_zone;
    w_dist_n  = r_dist;
    w_dv_n    = r_dv;
    w_dir_n   = r_dir;
    w_upd_n   = 1'b0;
    w_serr_n  = r_serr;
    if (w_filt) begin
      w_cand_n = gray_in;
      w_cnt_n  = w_cnt_f;
    end
    unique case (r_state)
      ACQ: begin
        w_idle_n = '0;
        if (w_commit) begin
          w_zone_n  = w_bin;
          w_dist_n  = {w_bin, 2'b10};
          w_dv_n    = 1'b1;
          w_dir_n   = 2'b00;
          w_state_n = LOCK;
        end
      end
      LOCK: begin
        if (gray_valid) begin
          w_idle_n = '0;
          if (w_commit && w_one) begin
            w_zone_n = w_bin;
            w_dist_n = {w_bin, 2'b10};
            w_upd_n  = 1'b1;
            w_dir_n  = (w_bin > r_zone) ? 2'b10 : 2'b01;
          end else if (w_commit && (w_diff != 3'd0)) begin
            w_state_n = ERR;
            w_serr_n  = 1'b1;
            w_dv_n    = 1'b0;
          end
        end else if (w_tout) begin
          w_state_n = ACQ;
          w_dv_n    = 1'b0;
          w_dir_n   = 2'b00;
          w_cand_n  = '0;
          w_cnt_n   = '0;
          w_idle_n  = '0;
        end else if (r_idle != '1) begin
          w_idle_n = r_idle + 1'b1;
        end
      end
      ERR: begin
        if (err_clr) begin
          w_state_n = ACQ;
          w_serr_n  = 1'b0;
          w_cand_n  = '0;
          w_cnt_n   = '0;
          w_idle_n  = '0;
        end
      end
      default: w_state_n = ACQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ACQ;
      r_cand  <= '0;
      r_cnt   <= '0;
      r_idle  <= '0;
      r_zone  <= '0;
      r_dist  <= '0;
      r_dv    <= 1'b0;
      r_dir   <= 2'b00;
      r_upd   <= 1'b0;
      r_serr  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cand  <= w_cand_n;
      r_cnt   <= w_cnt_n;
      r_idle  <= w_idle_n;
      r_zone  <= w_zone_n;
      r_dist  <= w_dist_n;
      r_dv    <= w_dv_n;
      r_dir   <= w_dir_n;
      r_upd   <= w_upd_n;
      r_serr  <= w_serr_n;
    end
  end

  assign zone       = r_zone;
  assign distance   = r_dist;
  assign dist_valid = r_dv;
  assign direction  = r_dir;
  assign update     = r_upd;
  assign step_error = r_serr;

endmodule
